multicycle_ctrl: RTL and testbench

- Multicycle control unit for the ARMv4 core. One shared ALU and one unified instruction/data memory port are sequenced over 3–5 cycles per instruction.
- Contains the main FSM, ALU-op decode (same ALUControl encoding as the single-cycle decoder), the NZCV flag register, and condition-code evaluation.
- Sits between the instruction register and the datapath muxes/enables. Stalls on a memory ready handshake.

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/cond_unit.sv | 33 +++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARMv4 control unit.
//   state_t        : main FSM states
//   ALU_*          : ALUControl encodings (same as the single-cycle decoder)
//   RES_* / SRCB_* : ResultSrc / ALUSrcB mux selects
//   COND_*         : instruction condition field values
//   cond_ex()      : ARM condition evaluation against an NZCV nibble
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MVN = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b0110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  // nzcv = {N, Z, C, V}
  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;  // NV: never executes
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register plus condition evaluation.
//   clk, reset : clock, async active-low reset (Flags cleared)
//   Cond       : instruction condition field
//   ALUFlags   : NZCV from the ALU this cycle
//   FlagW      : [1] load N,Z  [0] load C,V
//   flag_en    : qualifies FlagW (execute state, condition passed, legal op)
//   Flags      : registered NZCV
//   CondEx     : Cond evaluated against the registered flags
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       flag_en,
  output logic [3:0] Flags,
  output logic       CondEx
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= '0;
    end else if (flag_en) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign CondEx = cond_ex(Cond, Flags);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARMv4 control unit: main FSM, ALU-op decode, flags and
// condition gating for a datapath with one ALU and one unified memory port.
//   clk, reset        : clock, async active-low reset
//   Cond/Op/Funct/Rd/sh : instruction register fields
//   ALUFlags          : NZCV from the ALU this cycle
//   mem_ready         : memory access completes this cycle
//   PCWrite/IRWrite/RegWrite/MemWrite : datapath write enables
//   AdrSrc/ResultSrc/ALUSrcA/ALUSrcB/ImmSrc/RegSrc/ALUControl : mux selects
//   Flags             : registered NZCV
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [1:0] sh,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] Flags
);

  state_t     state, state_nx;
  logic       cond_q, cond_now, rdy;
  logic [3:0] alu_op;
  logic       legal, is_cmp, cv_op;
  logic       pc_we, ir_we, rf_we, mem_we;
  logic       flag_en;
  logic [1:0] flag_w;

  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  // ALU op decode; illegal codes fall back to ADD with all writes suppressed
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    is_cmp = 1'b0;
    cv_op  = 1'b0;
    case (Funct[4:1])
      4'b0000: alu_op = ALU_AND;
      4'b0001: alu_op = ALU_EOR;
      4'b0010: begin alu_op = ALU_SUB; cv_op = 1'b1; end
      4'b0100: begin alu_op = ALU_ADD; cv_op = 1'b1; end
      4'b1100: alu_op = ALU_ORR;
      4'b1111: alu_op = ALU_MVN;
      4'b1101: if (sh == 2'b11) alu_op = ALU_ROR; else legal = 1'b0;
      4'b1010: if (Funct[0]) begin
                 alu_op = ALU_SUB; cv_op = 1'b1; is_cmp = 1'b1;
               end else legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

  assign flag_en = ((state == EXECR) || (state == EXECI)) && cond_q && legal;
  assign flag_w  = {Funct[0], Funct[0] & cv_op};

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (flag_w),
    .flag_en  (flag_en),
    .Flags    (Flags),
    .CondEx   (cond_now)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      cond_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DECODE) cond_q <= cond_now;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    mem_we     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RM;
    ALUControl = ALU_ADD;
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01, Op == 2'b10};
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        if (rdy) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        // PC+4 again gives R15 = PC+8 for register reads
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        case (Op)
          2'b00:   state_nx = Funct[5] ? EXECI : EXECR;
          2'b01:   state_nx = MEMADR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      EXECR: begin
        ALUControl = alu_op;
        state_nx   = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_op;
        state_nx   = ALUWB;
      end
      ALUWB: begin
        rf_we    = cond_q && legal && !is_cmp;
        pc_we    = rf_we && (Rd == 4'hF);
        state_nx = FETCH;
      end
      MEMADR: begin
        ALUSrcB  = SRCB_IMM;
        state_nx = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (rdy) state_nx = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_RDATA;
        rf_we     = cond_q;
        pc_we     = cond_q && (Rd == 4'hF);
        state_nx  = FETCH;
      end
      MEMWR: begin
        // strobe held for the whole wait so the memory sees a stable request
        AdrSrc = 1'b1;
        mem_we = cond_q;
        if (rdy) state_nx = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        pc_we     = cond_q;
        state_nx  = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // enables are killed combinationally while reset is asserted
  assign PCWrite  = pc_we  & reset;
  assign IRWrite  = ir_we  & reset;
  assign RegWrite = rf_we  & reset;
  assign MemWrite = mem_we & reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk, reset, mem_ready;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op, sh;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0] ALUControl, Flags;

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .sh(sh), .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one entry per clock: stimulus for that cycle plus expected outputs
  typedef struct {
    string       nm;
    logic        rst, rdy;
    logic [3:0]  af, cond, rd;
    logic [1:0]  op, sh;
    logic [5:0]  funct;
    logic [17:0] val, msk;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0, miss = 0;

  localparam logic [3:0] NZ  = 4'b1010;  // ALUFlags noise outside execute
  localparam logic [1:0] DC2 = 2'b11;    // don't-care select
  localparam logic [3:0] DC4 = 4'hF;     // don't-care ALUControl
  localparam logic [1:0] ADC = 2'd2;     // don't-care AdrSrc

  logic [3:0] cur_cond, cur_rd;
  logic [1:0] cur_op, cur_sh;
  logic [5:0] cur_funct;
  logic       cur_rst;

  function automatic void set_instr(logic [3:0] c, logic [1:0] o, logic [5:0] f,
                                    logic [3:0] r, logic [1:0] s);
    cur_cond = c; cur_op = o; cur_funct = f; cur_rd = r; cur_sh = s;
  endfunction

  function automatic void push(string nm, logic rdy, logic [3:0] af, logic pcw,
                               logic mw, logic irw, logic rw, logic [1:0] adr,
                               logic [1:0] rs, logic [1:0] srcb, logic [3:0] alu,
                               logic [3:0] fl);
    exp_t e;
    e.nm = nm; e.rst = cur_rst; e.rdy = rdy; e.af = af;
    e.cond = cur_cond; e.op = cur_op; e.funct = cur_funct; e.rd = cur_rd; e.sh = cur_sh;
    e.val = {pcw, adr[0], mw, irw, rw, rs, 1'b0, srcb, alu, fl};
    e.msk = {1'b1, adr != ADC, 3'b111, {2{rs != DC2}}, 1'b0, {2{srcb != DC2}},
             {4{alu != DC4}}, 4'hF};
    sb.push_back(e);
  endfunction

  function automatic void push_fd(string p, logic [3:0] fl);
    push({p, "_fetch"},  1, NZ, 1, 0, 1, 0, 0, 2'b10, 2'b10, 4'h0, fl);
    push({p, "_decode"}, 1, NZ, 0, 0, 0, 0, ADC, 2'b10, 2'b10, 4'h0, fl);
  endfunction

  function automatic logic [17:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ALUControl, Flags};
  endfunction

  task automatic apply(input exp_t e);
    reset = e.rst; mem_ready = e.rdy; ALUFlags = e.af;
    Cond = e.cond; Op = e.op; Funct = e.funct; Rd = e.rd; sh = e.sh;
    #1;
  endtask

  task automatic test_reset();
    exp_t e; logic [17:0] got;
    cur_rst = 1'b0;
    set_instr(4'hE, 2'b00, 6'b001000, 4'd1, 2'b00);
    repeat (2) push("rst_hold", 1, NZ, 0, 0, 0, 0, 0, 2'b10, 2'b10, 4'h0, 4'h0);
    cur_rst = 1'b1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_add();
    exp_t e; logic [17:0] got;
    set_instr(4'hE, 2'b00, 6'b001000, 4'd1, 2'b00);
    push_fd("add", 4'h0);
    push("add_execr", 1, 4'hF, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h0, 4'h0);
    push("add_aluwb", 1, NZ, 0, 0, 0, 1, ADC, 2'b00, DC2, DC4, 4'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flags_branch();
    exp_t e; logic [17:0] got;
    set_instr(4'hE, 2'b00, 6'b000101, 4'd2, 2'b00);
    push_fd("subs1", 4'h0);
    push("subs1_execr", 1, 4'b0100, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h1, 4'h0);
    push("subs1_aluwb", 1, NZ, 0, 0, 0, 1, ADC, 2'b00, DC2, DC4, 4'b0100);
    set_instr(4'h0, 2'b10, 6'b101000, 4'd0, 2'b00);
    push_fd("beq1", 4'b0100);
    push("beq_taken", 1, NZ, 1, 0, 0, 0, ADC, 2'b10, 2'b01, 4'h0, 4'b0100);
    set_instr(4'hE, 2'b00, 6'b000101, 4'd2, 2'b00);
    push_fd("subs2", 4'b0100);
    push("subs2_execr", 1, 4'b0000, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h1, 4'b0100);
    push("subs2_aluwb", 1, NZ, 0, 0, 0, 1, ADC, 2'b00, DC2, DC4, 4'h0);
    set_instr(4'h0, 2'b10, 6'b101000, 4'd0, 2'b00);
    push_fd("beq2", 4'h0);
    push("beq_not_taken", 1, NZ, 0, 0, 0, 0, ADC, 2'b10, 2'b01, 4'h0, 4'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ldr_wait();
    exp_t e; logic [17:0] got;
    set_instr(4'hE, 2'b01, 6'b011001, 4'd3, 2'b00);
    push("ldr_fetch_stall", 0, NZ, 0, 0, 0, 0, 0, 2'b10, 2'b10, 4'h0, 4'h0);
    push_fd("ldr", 4'h0);
    push("ldr_memadr", 1, NZ, 0, 0, 0, 0, ADC, DC2, 2'b01, 4'h0, 4'h0);
    repeat (3) push("ldr_memrd_wait", 0, NZ, 0, 0, 0, 0, 1, DC2, DC2, DC4, 4'h0);
    push("ldr_memrd_done", 1, NZ, 0, 0, 0, 0, 1, DC2, DC2, DC4, 4'h0);
    push("ldr_memwb", 1, NZ, 0, 0, 0, 1, ADC, 2'b01, DC2, DC4, 4'h0);
    set_instr(4'hE, 2'b01, 6'b011001, 4'hF, 2'b00);
    push_fd("ldrpc", 4'h0);
    push("ldrpc_memadr", 1, NZ, 0, 0, 0, 0, ADC, DC2, 2'b01, 4'h0, 4'h0);
    push("ldrpc_memrd_wait", 0, NZ, 0, 0, 0, 0, 1, DC2, DC2, DC4, 4'h0);
    push("ldrpc_memrd_done", 1, NZ, 0, 0, 0, 0, 1, DC2, DC2, DC4, 4'h0);
    push("ldrpc_memwb", 1, NZ, 1, 0, 0, 1, ADC, 2'b01, DC2, DC4, 4'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  typedef struct packed {
    logic [5:0] f; logic [1:0] sh; logic [3:0] alu; logic rw; logic [1:0] srcb;
  } dec_t;

  task automatic test_alu_decode();
    exp_t e; logic [17:0] got;
    dec_t tbl [10];
    tbl = '{'{6'b000000, 2'b00, 4'b0010, 1'b1, 2'b00},   // AND
            '{6'b000010, 2'b00, 4'b0100, 1'b1, 2'b00},   // EOR
            '{6'b000100, 2'b00, 4'b0001, 1'b1, 2'b00},   // SUB
            '{6'b011000, 2'b00, 4'b0011, 1'b1, 2'b00},   // ORR
            '{6'b011110, 2'b00, 4'b0101, 1'b1, 2'b00},   // MVN
            '{6'b011010, 2'b11, 4'b0110, 1'b1, 2'b00},   // ROR
            '{6'b011010, 2'b00, 4'b0000, 1'b0, 2'b00},   // 1101 w/o ROR: illegal
            '{6'b101000, 2'b00, 4'b0000, 1'b1, 2'b01},   // ADD immediate
            '{6'b010100, 2'b00, 4'b0000, 1'b0, 2'b00},   // 1010 without S: illegal
            '{6'b000110, 2'b00, 4'b0000, 1'b0, 2'b00}};  // 0011: illegal
    foreach (tbl[i]) begin
      set_instr(4'hE, 2'b00, tbl[i].f, 4'd5, tbl[i].sh);
      push_fd("dec", 4'h0);
      push("dec_exec", 1, 4'hF, 0, 0, 0, 0, ADC, DC2, tbl[i].srcb, tbl[i].alu, 4'h0);
      push("dec_aluwb", 1, NZ, 0, 0, 0, tbl[i].rw, ADC, 2'b00, DC2, DC4, 4'h0);
    end
    set_instr(4'hF, 2'b00, 6'b001000, 4'd5, 2'b00);   // NV: never
    push_fd("nv", 4'h0);
    push("nv_execr", 1, 4'hF, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h0, 4'h0);
    push("nv_aluwb", 1, NZ, 0, 0, 0, 0, ADC, 2'b00, DC2, DC4, 4'h0);
    set_instr(4'hE, 2'b11, 6'b000000, 4'd5, 2'b00);   // Op=11 no-op
    push_fd("nop1", 4'h0);
    push_fd("nop2", 4'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flags();
    exp_t e; logic [17:0] got;
    set_instr(4'hE, 2'b00, 6'b010101, 4'd0, 2'b00);   // CMP
    push_fd("cmp", 4'h0);
    push("cmp_execr", 1, 4'hF, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h1, 4'h0);
    push("cmp_aluwb", 1, NZ, 0, 0, 0, 0, ADC, 2'b00, DC2, DC4, 4'hF);
    set_instr(4'hE, 2'b00, 6'b000111, 4'd6, 2'b00);   // illegal with S
    push_fd("ill", 4'hF);
    push("ill_execr", 1, 4'h0, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h0, 4'hF);
    push("ill_aluwb", 1, NZ, 0, 0, 0, 0, ADC, 2'b00, DC2, DC4, 4'hF);
    set_instr(4'hE, 2'b00, 6'b000001, 4'd6, 2'b00);   // ANDS: C,V kept
    push_fd("ands", 4'hF);
    push("ands_execr", 1, 4'b1000, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h2, 4'hF);
    push("ands_aluwb", 1, NZ, 0, 0, 0, 1, ADC, 2'b00, DC2, DC4, 4'b1011);
    set_instr(4'h0, 2'b00, 6'b001001, 4'd6, 2'b00);   // ADDSEQ, Z=0
    push_fd("addseq", 4'b1011);
    push("addseq_execr", 1, 4'b0100, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h0, 4'b1011);
    push("addseq_aluwb", 1, NZ, 0, 0, 0, 0, ADC, 2'b00, DC2, DC4, 4'b1011);
    set_instr(4'hE, 2'b00, 6'b010101, 4'd0, 2'b00);   // CMP -> Z=1
    push_fd("cmp2", 4'b1011);
    push("cmp2_execr", 1, 4'b0100, 0, 0, 0, 0, ADC, DC2, 2'b00, 4'h1, 4'b1011);
    push("cmp2_aluwb", 1, NZ, 0, 0, 0, 0, ADC, 2'b00, DC2, DC4, 4'b0100);
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_str();
    exp_t e; logic [17:0] got;
    set_instr(4'h1, 2'b01, 6'b011000, 4'd4, 2'b00);   // STRNE with Z=1
    push_fd("strne", 4'b0100);
    push("strne_memadr", 1, NZ, 0, 0, 0, 0, ADC, DC2, 2'b01, 4'h0, 4'b0100);
    push("strne_memwr_wait", 0, NZ, 0, 0, 0, 0, 1, DC2, DC2, DC4, 4'b0100);
    push("strne_memwr_done", 1, NZ, 0, 0, 0, 0, 1, DC2, DC2, DC4, 4'b0100);
    set_instr(4'hE, 2'b01, 6'b011000, 4'd4, 2'b00);   // STR always
    push_fd("str", 4'b0100);
    push("str_memadr", 1, NZ, 0, 0, 0, 0, ADC, DC2, 2'b01, 4'h0, 4'b0100);
    repeat (2) push("str_memwr_wait", 0, NZ, 0, 1, 0, 0, 1, DC2, DC2, DC4, 4'b0100);
    push("str_memwr_done", 1, NZ, 0, 1, 0, 0, 1, DC2, DC2, DC4, 4'b0100);
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e; logic [17:0] got;
    set_instr(4'hE, 2'b01, 6'b011000, 4'd4, 2'b00);
    push_fd("abort", 4'b0100);
    push("abort_memadr", 1, NZ, 0, 0, 0, 0, ADC, DC2, 2'b01, 4'h0, 4'b0100);
    push("abort_memwr", 0, NZ, 0, 1, 0, 0, 1, DC2, DC2, DC4, 4'b0100);
    cur_rst = 1'b0;
    repeat (2) push("abort_in_reset", 1, NZ, 0, 0, 0, 0, 0, 2'b10, 2'b10, 4'h0, 4'h0);
    cur_rst = 1'b1;
    push_fd("abort_after", 4'h0);
    push("abort_after_memadr", 1, NZ, 0, 0, 0, 0, ADC, DC2, 2'b01, 4'h0, 4'h0);
    push("abort_after_memwr", 1, NZ, 0, 1, 0, 0, 1, DC2, DC2, DC4, 4'h0);
    push("abort_final_fetch", 1, NZ, 1, 0, 1, 0, 0, 2'b10, 2'b10, 4'h0, 4'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); apply(e); got = obs(); vecs++;
      if ((got & e.msk) !== (e.val & e.msk)) begin
        miss++; $display("FAIL %s: got %b want %b care %b", e.nm, got, e.val, e.msk);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; ALUFlags = 4'h0;
    Cond = 4'hE; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; sh = 2'b00;
    cur_rst = 1'b1;
    set_instr(4'hE, 2'b00, 6'h0, 4'h0, 2'b00);
    @(negedge clk);
    test_reset();
    test_add();
    test_flags_branch();
    test_ldr_wait();
    test_alu_decode();
    test_flags();
    test_str();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
